// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller.
// Contents: FSM state encoding, default timing values, and the
// digit-index width helper used by the interface and the top.
package seven_seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_CLK_DIV      = 50000;
  localparam int DEF_BLANK_CYCLES = 16;

  // Width of a digit index; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_NUM_DIGITS);

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Bundle between the value producer / display drivers and the scan
// controller.
//   en, load, value_in          : producer -> controller
//   bcd_out, digit_en, blank,
//   digit_idx, frame_done,
//   pending                     : controller -> decoder / digit drivers
// master: producer side, slave: scan controller.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import seven_seg_scan_ctrl_pkg::*;

  localparam int IDX_W = idx_width(NUM_DIGITS);

  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    blank;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;
  logic                    pending;

  modport master (
    output en, load, value_in,
    input  bcd_out, digit_en, blank, digit_idx, frame_done, pending
  );

  modport slave (
    input  en, load, value_in,
    output bcd_out, digit_en, blank, digit_idx, frame_done, pending
  );

endinterface

// File: rtl/seven_seg_slot_timer.sv
// Down-counter timing one BLANK or SHOW phase.
//   clk, rst  : clock, synchronous active-high reset
//   load      : restart the count at load_val
//   load_val  : phase length minus one
//   tc        : count has reached zero (last cycle of the phase)
module seven_seg_slot_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)             cnt_d = load_val;
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a NUM_DIGITS 7-segment display
// sharing one external BCD decoder. A shadow register catches loads; the
// display register only changes when a scan starts or at a frame
// boundary, so a frame never mixes two values.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : seven_seg_scan_ctrl_if.slave (en/load/value_in in,
//              bcd_out/digit_en/blank/digit_idx/frame_done/pending out)
// All bus outputs are registered.
// Optional build macro SEVEN_SEG_LEADING_ZERO_BLANK_EN: keep digits above
// the most significant nonzero digit dark during their SHOW phase.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(CLK_DIV - BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  digits_t               shadow_q, shadow_d;
  digits_t               display_q, display_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  blank_q, blank_d;

  logic                  tmr_load;
  logic [CNT_W-1:0]      tmr_val;
  logic                  tmr_tc;
  logic                  apply;
  logic                  lit;

  seven_seg_slot_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // State register (FSM state plus all registered outputs).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      shadow_q     <= '0;
      display_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      bcd_q        <= '0;
      digit_en_q   <= '0;
      blank_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      bcd_q        <= bcd_d;
      digit_en_q   <= digit_en_d;
      blank_q      <= blank_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    display_d    = display_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = BLANK_LD;
    apply        = 1'b0;

    if (!bus.en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_BLANK;
          idx_d    = '0;
          tmr_load = 1'b1;
          apply    = 1'b1;
        end
        ST_BLANK: begin
          if (tmr_tc) begin
            state_d  = ST_SHOW;
            tmr_load = 1'b1;
            tmr_val  = SHOW_LD;
          end
        end
        ST_SHOW: begin
          if (tmr_tc) begin
            state_d  = ST_BLANK;
            tmr_load = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d        = '0;
              frame_done_d = 1'b1;
              apply        = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (apply && pending_q) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end
    // A load in the apply cycle lands in the shadow after the old shadow
    // has moved to display, so it waits a full frame.
    if (bus.load) begin
      shadow_d  = bus.value_in;
      pending_d = 1'b1;
    end
  end

  // Output logic, computed from next state so the outputs register in
  // step with the FSM.
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msnz;
  always_comb begin
    msnz = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (display_d[i] != 4'h0) msnz = IDX_W'(i);
  end
  assign lit = (idx_d <= msnz);
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    bcd_d      = display_d[idx_d];
    digit_en_d = '0;
    if (state_d == ST_SHOW && lit)
      digit_en_d = NUM_DIGITS'(1) << idx_d;
    blank_d    = (digit_en_d == '0);
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.blank      = blank_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .CLK_DIV      (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] val;
    logic [3:0]  de;
    logic [3:0]  bcd;
    logic        blank;
    logic        fd;
    logic        pend;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {21'b0, bus.frame_done, bus.pending, bus.blank, bus.digit_en, bus.bcd_out};
  endfunction

  function automatic logic [31:0] pack(logic fd, logic pend, logic blank,
                                        logic [3:0] de, logic [3:0] bcd);
    return {21'b0, fd, pend, blank, de, bcd};
  endfunction

  // One full frame started from IDLE with the given value; mask marks
  // which digits are expected lit.
  task automatic run_frame(input string name, input logic [15:0] v, input logic [3:0] mask);
    logic [3:0] de;
    bus.en = 1'b0;
    step();
    bus.load = 1'b1; bus.value_in = v;
    step();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    for (int c = 0; c < 32; c++) begin
      int slot, ph;
      step();
      slot = c / 8;
      ph   = c % 8;
      de   = (ph >= 2 && mask[slot]) ? (4'b0001 << slot) : 4'b0000;
      chk($sformatf("%s_c%0d", name, c), outs(),
          pack(1'b0, 1'b0, de == 4'b0, de, v[slot*4 +: 4]));
    end
    step();
    chk({name, "_fd"}, {31'b0, bus.frame_done}, 32'd1);
  endtask

  initial begin
    logic [15:0] disp [5];
    logic        pend;
    logic        fd_seen;
    logic [3:0]  m70, m00;
    int          n;

    // ---- stimulus table: five frames of continuous scan ----
    disp[0] = 16'h1234; disp[1] = 16'h5678; disp[2] = 16'h2222;
    disp[3] = 16'h2222; disp[4] = 16'h9876;
    pend = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int c = 0; c < 32; c++) begin
        vec_t v;
        logic [15:0] dv;
        int slot, ph;
        if (f == 4 && c >= 10) break;
        v.en = 1'b1; v.load = 1'b0; v.val = 16'h0;
        if (f == 0 && c == 11) begin v.load = 1'b1; v.val = 16'h5678; end // digit 1 lit
        if (f == 1 && c == 7)  begin v.load = 1'b1; v.val = 16'h1111; end
        if (f == 1 && c == 17) begin v.load = 1'b1; v.val = 16'h2222; end
        if (f == 3 && c == 0)  begin v.load = 1'b1; v.val = 16'h9876; end // apply cycle
        if (c == 0) pend = 1'b0;
        if (v.load) pend = 1'b1;
        slot    = c / 8;
        ph      = c % 8;
        dv      = disp[f];
        v.bcd   = dv[slot*4 +: 4];
        v.blank = (ph < 2);
        v.de    = (ph < 2) ? 4'b0000 : (4'b0001 << slot);
        v.fd    = (c == 0 && f > 0);
        v.pend  = pend;
        vecs.push_back(v);
      end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    m70 = 4'b0011; m00 = 4'b0001;
`else
    m70 = 4'b1111; m00 = 4'b1111;
`endif

    // ---- reset ----
    rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.value_in = '0;
    repeat (3) step();
    chk("rst_out", outs(), pack(1'b0, 1'b0, 1'b1, 4'b0, 4'h0));
    chk("rst_idx", {30'b0, bus.digit_idx}, 32'd0);
    rst = 1'b0;

    bus.load = 1'b1; bus.value_in = 16'h1234;
    step();
    bus.load = 1'b0;
    chk("load_idle", outs(), pack(1'b0, 1'b1, 1'b1, 4'b0, 4'h0));

    // ---- table-driven scan ----
    foreach (vecs[i]) begin
      bus.en = vecs[i].en; bus.load = vecs[i].load; bus.value_in = vecs[i].val;
      step();
      chk($sformatf("vec%0d", i), outs(),
          pack(vecs[i].fd, vecs[i].pend, vecs[i].blank, vecs[i].de, vecs[i].bcd));
    end
    bus.load = 1'b0;

    // ---- en drop mid-SHOW of digit 2 ----
    n = 0;
    while (bus.digit_en !== 4'b0100 && n < 64) begin step(); n++; end
    chk("wait_d2", {31'b0, bus.digit_en == 4'b0100}, 32'd1);
    step();
    bus.en = 1'b0;
    step();
    chk("en0_dark", outs(), pack(1'b0, 1'b0, 1'b1, 4'b0, bus.bcd_out));
    chk("en0_idx", {30'b0, bus.digit_idx}, 32'd0);
    fd_seen = 1'b0;
    repeat (5) begin step(); fd_seen |= bus.frame_done | (bus.digit_en != 4'b0); end
    chk("en0_quiet", {31'b0, fd_seen}, 32'd0);
    bus.load = 1'b1; bus.value_in = 16'h4321;
    step();
    bus.load = 1'b0;
    chk("en0_pend", {31'b0, bus.pending}, 32'd1);
    bus.en = 1'b1;
    step();
    chk("re_blank1", outs(), pack(1'b0, 1'b0, 1'b1, 4'b0, 4'h1));
    step();
    chk("re_blank2", outs(), pack(1'b0, 1'b0, 1'b1, 4'b0, 4'h1));
    step();
    chk("re_show0", outs(), pack(1'b0, 1'b0, 1'b0, 4'b0001, 4'h1));

    // ---- reset mid-frame clears shadow ----
    bus.load = 1'b1; bus.value_in = 16'h5555;
    step();
    bus.load = 1'b0;
    chk("pre_rst_pend", {31'b0, bus.pending}, 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst", outs(), pack(1'b0, 1'b0, 1'b1, 4'b0, 4'h0));
    rst = 1'b0;
    repeat (3) step();
    chk("post_rst", outs(), pack(1'b0, 1'b0, 1'b0, 4'b0001, 4'h0));

    // ---- leading-zero handling ----
    run_frame("lz70", 16'h0070, m70);
    run_frame("lz00", 16'h0000, m00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
